// File: rtl/hamming_scrubber.sv
// Background scrubber for Hamming-protected codewords: walks every address,
// writes back single-bit corrections and keeps correction statistics.
module hamming_scrubber #(
   parameter int parity_bits = 4,
   parameter int depth       = 16,
   parameter int interval    = 8,
   localparam int W  = (1 << parity_bits) - 1,
   localparam int AW = $clog2(depth)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   clear_count,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [AW-1:0]          mem_addr,
   output logic [W-1:0]           mem_wdata,
   input  logic                   mem_gnt,
   input  logic [W-1:0]           mem_rdata,
   output logic                   busy,
   output logic                   pass_done,
   output logic [15:0]            corr_count,
   output logic [AW-1:0]          last_corr_addr,
   output logic [parity_bits-1:0] last_syndrome
);
   // state | meaning
   // IDLE  | stopped, address counter held at 0
   // WAIT  | idle gap of `interval` cycles before the next read
   // READ  | read request for the current address, held until granted
   // CHECK | read data valid, syndrome evaluated
   // WRITE | write-back of the corrected word, held until granted
   // NEXT  | advance/wrap address, pass_done on the last word
   localparam int CW = (interval > 1) ? $clog2(interval) : 1;

   typedef enum logic [2:0] {IDLE, WAIT, READ, CHECK, WRITE, NEXT} state_t;

   state_t                 state, state_nxt, resume;
   logic [AW-1:0]          addr;
   logic [CW-1:0]          wait_cnt;
   logic [parity_bits-1:0] syndrome, syndrome_q;
   logic [W-1:0]           flip_mask;
   logic                   last_addr;

   assign mem_addr  = addr;
   assign last_addr = (addr == AW'(depth - 1));

   always_comb begin
      syndrome  = '0;
      flip_mask = '0;
      for (int p = 1; p <= W; p++) begin
         if (mem_rdata[p-1]) syndrome ^= parity_bits'(p);
      end
      for (int p = 1; p <= W; p++) begin
         if (syndrome == parity_bits'(p)) flip_mask[p-1] = 1'b1;
      end
   end

   always_comb begin
      resume    = (interval == 0) ? READ : WAIT;
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = resume;
         WAIT: begin
            if (!enable)               state_nxt = IDLE;
            else if (wait_cnt == '0)   state_nxt = READ;
         end
         READ: begin
            // reads have no side effects, so dropping one on abort is harmless
            if (!enable)               state_nxt = IDLE;
            else if (mem_gnt)          state_nxt = CHECK;
         end
         CHECK:   state_nxt = (syndrome == '0) ? NEXT : WRITE;
         WRITE:   if (mem_gnt) state_nxt = NEXT;
         NEXT:    state_nxt = enable ? resume : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         addr           <= '0;
         wait_cnt       <= '0;
         syndrome_q     <= '0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_wdata      <= '0;
         busy           <= 1'b0;
         pass_done      <= 1'b0;
         corr_count     <= '0;
         last_corr_addr <= '0;
         last_syndrome  <= '0;
      end else begin
         state     <= state_nxt;
         mem_req   <= (state_nxt == READ) || (state_nxt == WRITE);
         mem_we    <= (state_nxt == WRITE);
         busy      <= (state_nxt != IDLE);
         pass_done <= (state_nxt == NEXT) && last_addr;

         if (state_nxt == IDLE)
            addr <= '0;
         else if (state == NEXT)
            addr <= last_addr ? '0 : addr + 1'b1;

         if (state_nxt == WAIT && state != WAIT)
            wait_cnt <= CW'(interval - 1);
         else if (state == WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;

         if (state == CHECK && syndrome != '0) begin
            mem_wdata  <= mem_rdata ^ flip_mask;
            syndrome_q <= syndrome;
         end

         if (state == WRITE && mem_gnt) begin
            last_corr_addr <= addr;
            last_syndrome  <= syndrome_q;
         end

         if (clear_count)
            corr_count <= '0;
         else if (state == WRITE && mem_gnt && corr_count != 16'hFFFF)
            corr_count <= corr_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_hamming_scrubber.sv
// Directed bench for hamming_scrubber: a small memory model answers the
// scrubber, each task drives one scenario and checks hand-derived values.
module tb_hamming_scrubber;
   localparam int PB = 4, DEPTH = 16, W = 15, AW = 4;
   // positions {3,5,6} set: 3^5^6 = 0, a valid codeword; flipping position 5 gives syndrome 5
   localparam logic [W-1:0] CLEAN = 15'h0034;
   localparam logic [W-1:0] BAD   = 15'h0024;

   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clear_count = 1'b0, gnt = 1'b0;
   logic          mem_req, mem_we, busy, pass_done;
   logic [AW-1:0] mem_addr, last_corr_addr;
   logic [W-1:0]  mem_wdata, mem_rdata;
   logic [15:0]   corr_count;
   logic [PB-1:0] last_syndrome;

   logic          enable_w = 1'b0;
   logic          req_w, we_w, busy_w, pd_w;
   logic [AW-1:0] addr_w, lca_w;
   logic [W-1:0]  wdata_w;
   logic [15:0]   cc_w;
   logic [PB-1:0] ls_w;

   logic [W-1:0]  mem [DEPTH];
   logic          inj_en = 1'b0, model_clear = 1'b0;
   logic [AW-1:0] inj_addr = '0;
   logic [W-1:0]  inj_data = '0;

   int passed = 0, total = 0;

   always #5 clk = ~clk;

   hamming_scrubber #(.parity_bits(PB), .depth(DEPTH), .interval(0)) dut (
      .clk(clk), .reset(rst), .enable(enable), .clear_count(clear_count),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(gnt), .mem_rdata(mem_rdata), .busy(busy), .pass_done(pass_done),
      .corr_count(corr_count), .last_corr_addr(last_corr_addr), .last_syndrome(last_syndrome));

   hamming_scrubber #(.parity_bits(PB), .depth(DEPTH), .interval(2)) dut_w (
      .clk(clk), .reset(rst), .enable(enable_w), .clear_count(1'b0),
      .mem_req(req_w), .mem_we(we_w), .mem_addr(addr_w), .mem_wdata(wdata_w),
      .mem_gnt(1'b1), .mem_rdata(15'h0000), .busy(busy_w), .pass_done(pd_w),
      .corr_count(cc_w), .last_corr_addr(lca_w), .last_syndrome(ls_w));

   always @(posedge clk) begin
      if (model_clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (inj_en)
         mem[inj_addr] <= inj_data;
      else if (mem_req && gnt && mem_we)
         mem[mem_addr] <= mem_wdata;
      if (mem_req && gnt && !mem_we)
         mem_rdata <= mem[mem_addr];
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic inject(input int a, input logic [W-1:0] d);
      inj_en = 1'b1; inj_addr = AW'(a); inj_data = d;
      step();
      inj_en = 1'b0;
   endtask

   task automatic clear_mem();
      model_clear = 1'b1;
      step();
      model_clear = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_count = 1'b1;
      step();
      clear_count = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!busy) begin ok = 1'b1; break; end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, busy, pass_done, corr_count, last_corr_addr, last_syndrome} !== '0)
         $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h busy=%b pd=%b cnt=%h lca=%h ls=%h, want all 0",
                  mem_req, mem_we, mem_addr, mem_wdata, busy, pass_done, corr_count, last_corr_addr, last_syndrome);
      else passed++;
      total++;
      if ({req_w, we_w, addr_w, wdata_w, busy_w, pd_w, cc_w, lca_w, ls_w} !== '0)
         $display("FAIL reset_outputs_w: got req=%b busy=%b addr=%h, want all 0", req_w, busy_w, addr_w);
      else passed++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_clean_pass();
      int nreads, nwrites, pd_cnt, pd_cyc, addr_err;
      bit ok;
      nreads = 0; nwrites = 0; pd_cnt = 0; pd_cyc = -1; addr_err = 0;
      clear_mem();
      gnt = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         step();
         if (mem_req && gnt && !mem_we) begin
            if (mem_addr !== AW'(nreads)) addr_err++;
            nreads++;
         end
         if (mem_req && mem_we) nwrites++;
         if (pass_done) begin
            pd_cnt++;
            if (pd_cyc < 0) pd_cyc = k;
         end
      end
      total++; if (nreads != 16) $display("FAIL clean_reads: got %0d want 16", nreads); else passed++;
      total++; if (addr_err != 0) $display("FAIL clean_read_order: got %0d bad addresses want 0", addr_err); else passed++;
      total++; if (nwrites != 0) $display("FAIL clean_writes: got %0d want 0", nwrites); else passed++;
      total++; if (pd_cnt != 1) $display("FAIL clean_pass_done_count: got %0d want 1", pd_cnt); else passed++;
      total++; if (pd_cyc != 48) $display("FAIL clean_pass_done_cycle: got %0d want 48", pd_cyc); else passed++;
      step();
      total++;
      if (!(mem_req && !mem_we && mem_addr == 0 && !pass_done))
         $display("FAIL clean_wrap: got req=%b we=%b addr=%0d pd=%b want req=1 we=0 addr=0 pd=0", mem_req, mem_we, mem_addr, pass_done);
      else passed++;
      enable = 1'b0;
      step();
      total++; if (busy !== 1'b0) $display("FAIL abort_read: got busy=%b want 0", busy); else passed++;
      wait_idle(ok);
   endtask

   task automatic test_single_error();
      int nw, pd_cyc, nw2, pd2;
      logic [AW-1:0] waddr;
      logic [W-1:0]  wdata;
      bit ok;
      nw = 0; pd_cyc = -1; nw2 = 0; pd2 = -1; waddr = '0; wdata = '0;
      clear_mem();
      inject(3, BAD); inject(5, CLEAN); inject(10, CLEAN);
      pulse_clear();
      gnt = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 49; k++) begin
         step();
         if (mem_req && gnt && mem_we) begin nw++; waddr = mem_addr; wdata = mem_wdata; end
         if (pass_done && pd_cyc < 0) pd_cyc = k;
      end
      total++; if (nw != 1) $display("FAIL err_write_count: got %0d want 1", nw); else passed++;
      total++; if (waddr !== 4'd3) $display("FAIL err_write_addr: got %0d want 3", waddr); else passed++;
      total++; if (wdata !== CLEAN) $display("FAIL err_write_data: got %h want %h", wdata, CLEAN); else passed++;
      total++; if (pd_cyc != 49) $display("FAIL err_pass_cycle: got %0d want 49", pd_cyc); else passed++;
      total++; if (corr_count !== 16'd1) $display("FAIL err_corr_count: got %0d want 1", corr_count); else passed++;
      total++; if (last_corr_addr !== 4'd3) $display("FAIL err_last_addr: got %0d want 3", last_corr_addr); else passed++;
      total++; if (last_syndrome !== 4'd5) $display("FAIL err_last_syndrome: got %0d want 5", last_syndrome); else passed++;
      for (int k = 50; k <= 97; k++) begin
         step();
         if (mem_req && gnt && mem_we) nw2++;
         if (pass_done && pd2 < 0) pd2 = k;
      end
      total++; if (nw2 != 0) $display("FAIL rescrub_writes: got %0d want 0", nw2); else passed++;
      total++; if (pd2 != 97) $display("FAIL rescrub_pass_cycle: got %0d want 97", pd2); else passed++;
      total++; if (mem[3] !== CLEAN) $display("FAIL rescrub_mem: got %h want %h", mem[3], CLEAN); else passed++;
      enable = 1'b0;
      wait_idle(ok);
      total++; if (!ok) $display("FAIL err_idle_timeout: got busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_stall();
      int err, nw;
      bit found;
      err = 0; nw = 0; found = 1'b0;
      clear_mem();
      inject(1, BAD);
      pulse_clear();
      gnt = 1'b0; enable = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         if (!(mem_req && !mem_we && mem_addr == 0)) err++;
         step();
      end
      total++; if (err != 0) $display("FAIL stall_read: got %0d unstable cycles want 0", err); else passed++;
      gnt = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (mem_req && mem_we) begin found = 1'b1; break; end
      end
      gnt = 1'b0;
      total++; if (!found) $display("FAIL stall_write_timeout: got no write request want one"); else passed++;
      err = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (!(mem_req && mem_we && mem_addr == 1 && mem_wdata == CLEAN)) err++;
      end
      total++; if (err != 0) $display("FAIL stall_write: got %0d unstable cycles want 0", err); else passed++;
      total++; if (corr_count !== 16'd0) $display("FAIL stall_no_count: got %0d want 0", corr_count); else passed++;
      gnt = 1'b1; enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_req && gnt && mem_we) nw++;
         if (!busy) break;
         step();
      end
      total++; if (nw != 1) $display("FAIL stall_write_count: got %0d want 1", nw); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL stall_idle: got busy=%b want 0", busy); else passed++;
      total++; if (corr_count !== 16'd1 || last_corr_addr !== 4'd1)
         $display("FAIL stall_stats: got cnt=%0d addr=%0d want cnt=1 addr=1", corr_count, last_corr_addr);
      else passed++;
   endtask

   task automatic test_saturation();
      int nw;
      logic g;
      logic [15:0] seen [4];
      bit ok, found;
      nw = 0; g = 1'b0; found = 1'b0;
      for (int i = 0; i < 4; i++) seen[i] = '0;
      clear_mem();
      for (int i = 0; i < 4; i++) inject(i, BAD);
      force dut.corr_count = 16'hFFFD;
      step();
      release dut.corr_count;
      step();
      total++; if (corr_count !== 16'hFFFD) $display("FAIL sat_preload: got %h want fffd", corr_count); else passed++;
      gnt = 1'b1; enable = 1'b1;
      for (int k = 0; k < 40 && nw < 4; k++) begin
         step();
         if (g) begin seen[nw] = corr_count; nw++; end
         g = mem_req && gnt && mem_we;
      end
      total++; if (nw != 4) $display("FAIL sat_writes: got %0d want 4", nw); else passed++;
      total++; if (seen[0] !== 16'hFFFE) $display("FAIL sat_first: got %h want fffe", seen[0]); else passed++;
      total++; if (seen[1] !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", seen[1]); else passed++;
      total++; if (seen[3] !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", seen[3]); else passed++;
      enable = 1'b0;
      wait_idle(ok);
      inject(9, BAD);
      enable = 1'b1;
      for (int k = 0; k < 60; k++) begin
         step();
         if (mem_req && mem_we) begin found = 1'b1; break; end
      end
      total++; if (!found) $display("FAIL clr_write_timeout: got no write request want one"); else passed++;
      clear_count = 1'b1;
      step();
      clear_count = 1'b0;
      total++; if (corr_count !== 16'd0) $display("FAIL clr_wins: got %h want 0", corr_count); else passed++;
      total++; if (last_corr_addr !== 4'd9 || last_syndrome !== 4'd5)
         $display("FAIL clr_stats: got addr=%0d syn=%0d want addr=9 syn=5", last_corr_addr, last_syndrome);
      else passed++;
      enable = 1'b0;
      wait_idle(ok);
   endtask

   task automatic test_enable_drop();
      int err, nw;
      bit found;
      err = 0; nw = 0; found = 1'b0;
      clear_mem();
      inject(7, BAD);
      pulse_clear();
      gnt = 1'b1; enable = 1'b1;
      for (int k = 0; k < 60; k++) begin
         step();
         if (mem_req && mem_we) begin found = 1'b1; break; end
      end
      total++; if (!found || mem_addr !== 4'd7)
         $display("FAIL drop_write_req: got found=%b addr=%0d want 1 and 7", found, mem_addr);
      else passed++;
      gnt = 1'b0; enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (!(mem_req && mem_we && busy && mem_addr == 7)) err++;
      end
      total++; if (err != 0) $display("FAIL drop_write_held: got %0d bad cycles want 0", err); else passed++;
      gnt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (mem_req && gnt && mem_we) nw++;
         if (!busy) break;
         step();
      end
      total++; if (nw != 1) $display("FAIL drop_write_count: got %0d want 1", nw); else passed++;
      total++; if (busy !== 1'b0 || mem_addr !== 4'd0)
         $display("FAIL drop_idle: got busy=%b addr=%0d want 0 and 0", busy, mem_addr);
      else passed++;
      total++; if (corr_count !== 16'd1 || last_corr_addr !== 4'd7)
         $display("FAIL drop_stats: got cnt=%0d addr=%0d want 1 and 7", corr_count, last_corr_addr);
      else passed++;
      step(); step();
      total++; if (mem_req !== 1'b0) $display("FAIL drop_stay_idle: got req=%b want 0", mem_req); else passed++;

      enable_w = 1'b1;
      step();
      total++; if (!(busy_w && !req_w)) $display("FAIL wait_state: got busy=%b req=%b want 1 0", busy_w, req_w); else passed++;
      enable_w = 1'b0;
      step();
      total++; if (busy_w !== 1'b0 || req_w !== 1'b0)
         $display("FAIL wait_abort: got busy=%b req=%b want 0 0", busy_w, req_w);
      else passed++;
      step();
      total++; if (req_w !== 1'b0) $display("FAIL wait_no_access: got req=%b want 0", req_w); else passed++;
   endtask

   task automatic test_reset_in_check();
      int nw;
      bit found, ok;
      nw = 0; found = 1'b0;
      clear_mem();
      inject(0, BAD);
      gnt = 1'b1; enable = 1'b1;
      step(); step();
      total++; if (!(busy && !mem_req)) $display("FAIL rst_in_check_state: got busy=%b req=%b want 1 0", busy, mem_req); else passed++;
      #1 rst = 1'b1;
      #1;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, busy, pass_done, corr_count, last_corr_addr, last_syndrome} !== '0)
         $display("FAIL rst_async: got req=%b busy=%b cnt=%h wdata=%h, want all 0", mem_req, busy, corr_count, mem_wdata);
      else passed++;
      enable = 1'b0;
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (mem_req && mem_we) nw++;
      end
      total++; if (nw != 0 || mem[0] !== BAD) $display("FAIL rst_no_write: got writes=%0d mem0=%h want 0 and %h", nw, mem[0], BAD); else passed++;
      enable = 1'b1;
      step();
      total++; if (!(mem_req && !mem_we && mem_addr == 0))
         $display("FAIL rst_restart: got req=%b we=%b addr=%0d want 1 0 0", mem_req, mem_we, mem_addr);
      else passed++;
      for (int k = 0; k < 10; k++) begin
         step();
         if (mem_req && mem_we) begin found = 1'b1; break; end
      end
      total++; if (!found || mem_addr !== 4'd0 || mem_wdata !== CLEAN)
         $display("FAIL rst_rescrub: got found=%b addr=%0d wdata=%h want 1 0 %h", found, mem_addr, mem_wdata, CLEAN);
      else passed++;
      enable = 1'b0;
      wait_idle(ok);
      total++; if (!ok) $display("FAIL rst_final_idle: got busy=%b want 0", busy); else passed++;
   endtask

   initial begin
      test_reset();
      test_clean_pass();
      test_single_error();
      test_stall();
      test_saturation();
      test_enable_drop();
      test_reset_in_check();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
